// File: rtl/nco_dac_multi.sv
// Dual-output NCO: phase accumulator -> pipelined CORDIC -> per-channel mode/scale/saturate -> offset-binary DAC words.
// Define NCO_DITHER_EN to add LFSR phase dither (DBITS LSBs) ahead of the CORDIC.
module nco_dac_multi #(
  parameter int PW      = 19,
  parameter int IW      = 12,
  parameter int OW      = 12,
  parameter int WW      = 15,
  parameter int NSTAGES = 15,
  parameter int AW      = 12,
  parameter int DW      = 14,
  parameter int DBITS   = 4
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [PW-1:0] cfg_phase_inc,
  input  logic [PW-1:0] cfg_phase_ofs,
  input  logic [AW-1:0] cfg_amp,
  input  logic [1:0]    cfg_mode1,
  input  logic [1:0]    cfg_mode2,
  input  logic          cfg_sync_wrap,
  input  logic          cfg_phase_clr,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic          cfg_ovr,
  output logic          out_valid,
  output logic [DW-1:0] dac1_data,
  output logic [DW-1:0] dac2_data
);

  localparam int LC      = NSTAGES + 2;
  localparam int SBW     = AW + 5;
  localparam int OSH     = WW - 1 - OW;
  localparam int PT      = OW + AW + 1;
  localparam int PRELOAD = int'((2.0 ** (IW - 1)) / 1.164435);
  localparam logic [DW-1:0]        MID  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [OW-1:0] SMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};
  localparam logic signed [WW:0]   RMAX = (WW+1)'(2 ** (OW - 1) - 1);
  localparam logic signed [WW:0]   RMIN = (WW+1)'(-(2 ** (OW - 1)));
  localparam logic signed [PT-1:0] PMAX = PT'(2 ** (OW - 1) - 1);
  localparam logic signed [PT-1:0] PMIN = PT'(-(2 ** (OW - 1)));
  localparam logic signed [WW-1:0] XPRE = WW'(PRELOAD) << (WW - IW - 1);

  function automatic logic [31:0] atan32(input int i);
    case (i)
      1:  return 32'd316933406;
      2:  return 32'd167458907;
      3:  return 32'd85004756;
      4:  return 32'd42667331;
      5:  return 32'd21354465;
      6:  return 32'd10679838;
      7:  return 32'd5340245;
      8:  return 32'd2670163;
      9:  return 32'd1335087;
      10: return 32'd667544;
      11: return 32'd333772;
      12: return 32'd166886;
      13: return 32'd83443;
      14: return 32'd41722;
      15: return 32'd20861;
      16: return 32'd10430;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [PW-1:0] atan_ang(input int i);
    logic [32:0] t;
    t = {1'b0, atan32(i)} + (33'd1 << (31 - PW));
    return PW'(t >> (32 - PW));
  endfunction

  function automatic logic signed [OW-1:0] sat_out(input logic signed [WW-1:0] v);
    logic signed [WW:0] r;
    r = ($signed({v[WW-1], v}) + (WW+1)'(2 ** (OSH - 1))) >>> OSH;
    if (r > RMAX) return SMAX;
    else if (r < RMIN) return SMIN;
    else return r[OW-1:0];
  endfunction

  function automatic logic signed [OW-1:0] sel_mode(input logic [1:0] m,
                                                    input logic signed [OW-1:0] s,
                                                    input logic signed [OW-1:0] c);
    case (m)
      2'b00:   return s;
      2'b01:   return c;
      2'b10:   return (s == SMIN) ? SMAX : -s;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [OW-1:0] scale_sat(input logic signed [OW-1:0] s,
                                                     input logic [AW-1:0] a);
    logic signed [PT-1:0] p;
    p = PT'(s) * PT'($signed({1'b0, a}));
    p = (p + PT'(2 ** (AW - 2))) >>> (AW - 1);
    if (p > PMAX) return SMAX;
    else if (p < PMIN) return SMIN;
    else return p[OW-1:0];
  endfunction

  function automatic logic [DW-1:0] to_dac(input logic signed [OW-1:0] s);
    logic [OW-1:0] u;
    u = {~s[OW-1], s[OW-2:0]};
    return DW'(u) << (DW - OW);
  endfunction

  logic [PW-1:0] acc, inc_act, ofs_act, p_inc, p_ofs;
  logic [AW-1:0] amp_act, p_amp;
  logic [1:0]    mode1_act, mode2_act, p_mode1, p_mode2;
  logic          p_clr, apply_now;
  logic [PW:0]   acc_sum;
  logic          wrap, apply;

  assign acc_sum = {1'b0, acc} + {1'b0, inc_act};
  assign wrap    = en & acc_sum[PW];
  assign apply   = apply_now | (cfg_busy & wrap);

  // Shadow capture and atomic apply; a sync-wrap commit waits for the accumulator carry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; inc_act <= '0; ofs_act <= '0; amp_act <= '0;
      mode1_act <= 2'b11; mode2_act <= 2'b11;
      p_inc <= '0; p_ofs <= '0; p_amp <= '0; p_mode1 <= 2'b11; p_mode2 <= 2'b11;
      p_clr <= 1'b0; apply_now <= 1'b0; cfg_busy <= 1'b0; cfg_ovr <= 1'b0;
    end else begin
      cfg_ovr   <= cfg_commit & cfg_busy;
      apply_now <= 1'b0;
      if (cfg_commit && !cfg_busy) begin
        p_inc <= cfg_phase_inc; p_ofs <= cfg_phase_ofs; p_amp <= cfg_amp;
        p_mode1 <= cfg_mode1; p_mode2 <= cfg_mode2; p_clr <= cfg_phase_clr;
        if (cfg_sync_wrap) cfg_busy <= 1'b1;
        else apply_now <= 1'b1;
      end
      if (cfg_busy && wrap) cfg_busy <= 1'b0;
      if (apply) begin
        inc_act <= p_inc; ofs_act <= p_ofs; amp_act <= p_amp;
        mode1_act <= p_mode1; mode2_act <= p_mode2;
      end
      if (apply && p_clr) acc <= '0;
      else if (en) acc <= acc_sum[PW-1:0];
    end
  end

  logic [DBITS-1:0] dith;
`ifdef NCO_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign dith = lfsr[DBITS-1:0];
`else
  assign dith = '0;
`endif

  logic [PW-1:0]  phase_r;
  logic [SBW-1:0] side_r;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= '0;
      side_r  <= '0;
    end else begin
      phase_r <= acc + ofs_act + PW'(dith);
      side_r  <= {en, mode1_act, mode2_act, amp_act};
    end
  end

  // Exact quarter-turn pre-rotation leaves a residual within +/-45 deg, so iterations start at i=1.
  logic [1:0]              quad;
  logic [PW-1:0]           z0;
  logic signed [WW-1:0]    cx [0:NSTAGES];
  logic signed [WW-1:0]    cy [0:NSTAGES];
  logic signed [PW-1:0]    cz [0:NSTAGES-1];
  logic [SBW-1:0]          sd [0:LC-1];
  logic signed [OW-1:0]    cos_c, sin_c;

  assign quad = phase_r[PW-1:PW-2] + {1'b0, phase_r[PW-3]};
  assign z0   = phase_r - {quad, {(PW-2){1'b0}}};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= NSTAGES; k++) begin cx[k] <= '0; cy[k] <= '0; end
      for (int k = 0; k < NSTAGES; k++) cz[k] <= '0;
      for (int k = 0; k < LC; k++) sd[k] <= '0;
      cos_c <= '0; sin_c <= '0;
    end else begin
      case (quad)
        2'd0:    begin cx[0] <= XPRE;  cy[0] <= '0;    end
        2'd1:    begin cx[0] <= '0;    cy[0] <= XPRE;  end
        2'd2:    begin cx[0] <= -XPRE; cy[0] <= '0;    end
        default: begin cx[0] <= '0;    cy[0] <= -XPRE; end
      endcase
      cz[0] <= z0;
      for (int k = 0; k < NSTAGES; k++) begin
        if (cz[k][PW-1]) begin
          cx[k+1] <= cx[k] + (cy[k] >>> (k + 1));
          cy[k+1] <= cy[k] - (cx[k] >>> (k + 1));
        end else begin
          cx[k+1] <= cx[k] - (cy[k] >>> (k + 1));
          cy[k+1] <= cy[k] + (cx[k] >>> (k + 1));
        end
      end
      for (int k = 0; k < NSTAGES - 1; k++)
        cz[k+1] <= cz[k][PW-1] ? cz[k] + atan_ang(k + 1) : cz[k] - atan_ang(k + 1);
      sd[0] <= side_r;
      for (int k = 1; k < LC; k++) sd[k] <= sd[k-1];
      cos_c <= sat_out(cx[NSTAGES]);
      sin_c <= sat_out(cy[NSTAGES]);
    end
  end

  logic signed [OW-1:0] s1_a, s1_b, s2_a, s2_b;
  logic                 s1_mute1, s1_mute2, s2_mute1, s2_mute2, s1_valid, s2_valid;
  logic [AW-1:0]        s1_amp;

  // Mode and amplitude ride the sideband so they always match the sample they act on.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a <= '0; s1_b <= '0; s2_a <= '0; s2_b <= '0;
      s1_mute1 <= 1'b1; s1_mute2 <= 1'b1; s2_mute1 <= 1'b1; s2_mute2 <= 1'b1;
      s1_valid <= 1'b0; s2_valid <= 1'b0; s1_amp <= '0;
      out_valid <= 1'b0; dac1_data <= MID; dac2_data <= MID;
    end else begin
      s1_a     <= sel_mode(sd[LC-1][AW+3:AW+2], sin_c, cos_c);
      s1_b     <= sel_mode(sd[LC-1][AW+1:AW], sin_c, cos_c);
      s1_mute1 <= (sd[LC-1][AW+3:AW+2] == 2'b11);
      s1_mute2 <= (sd[LC-1][AW+1:AW] == 2'b11);
      s1_valid <= sd[LC-1][SBW-1];
      s1_amp   <= sd[LC-1][AW-1:0];
      s2_a     <= scale_sat(s1_a, s1_amp);
      s2_b     <= scale_sat(s1_b, s1_amp);
      s2_mute1 <= s1_mute1;
      s2_mute2 <= s1_mute2;
      s2_valid <= s1_valid;
      out_valid <= s2_valid;
      dac1_data <= (s2_valid && !s2_mute1) ? to_dac(s2_a) : MID;
      dac2_data <= (s2_valid && !s2_mute2) ? to_dac(s2_b) : MID;
    end
  end

endmodule

// File: tb/tb_nco_dac_multi.sv
// Randomized bench for nco_dac_multi against a real-arithmetic sine/cosine reference model.
module tb_nco_dac_multi;
  localparam int PW  = 19;
  localparam int AW  = 12;
  localparam int OW  = 12;
  localparam int DW  = 14;
  localparam int LAT = 15 + 2 + 3;
  localparam int M   = 1 << PW;
  localparam int MID = 1 << (DW - 1);

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [PW-1:0] cfg_phase_inc, cfg_phase_ofs;
  logic [AW-1:0] cfg_amp;
  logic [1:0]    cfg_mode1, cfg_mode2;
  logic          cfg_sync_wrap, cfg_phase_clr, cfg_commit;
  logic          cfg_busy, cfg_ovr, out_valid;
  logic [DW-1:0] dac1_data, dac2_data;

  nco_dac_multi dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en),
    .cfg_phase_inc(cfg_phase_inc), .cfg_phase_ofs(cfg_phase_ofs), .cfg_amp(cfg_amp),
    .cfg_mode1(cfg_mode1), .cfg_mode2(cfg_mode2), .cfg_sync_wrap(cfg_sync_wrap),
    .cfg_phase_clr(cfg_phase_clr), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .cfg_ovr(cfg_ovr), .out_valid(out_valid), .dac1_data(dac1_data), .dac2_data(dac2_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit valid;
    int phase;
    int m1;
    int m2;
    int amp;
  } rec_t;

  rec_t hist[$];
  int   m_acc, m_inc, m_ofs, m_amp, m_m1, m_m2;
  int   p_inc, p_ofs, p_amp, p_m1, p_m2;
  bit   p_clr, m_busy, m_imm, m_ovr;
  int   checks, errors;

  task automatic checkOutput(input string tag, input int obs, input int expv, input int tol);
    checks++;
    if (obs < expv - tol || obs > expv + tol) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d (tol %0d)", tag, obs, expv, tol);
    end
  endtask

  // Ideal channel word: trig value at unity = 2048 LSB, clipped, scaled by amp/2048, clipped.
  function automatic int exp_dac(input bit valid, input int phase, input int mode, input int amp,
                                 output int tol);
    real ang, s;
    tol = 0;
    if (!valid || mode == 3) return MID;
    ang = 2.0 * 3.14159265358979 * phase / (2.0 ** PW);
    case (mode)
      0: s = $sin(ang);
      1: s = $cos(ang);
      default: s = -$sin(ang);
    endcase
    s = s * 2048.0;
    if (s > 2047.0) s = 2047.0;
    if (s < -2048.0) s = -2048.0;
    s = s * amp / 2048.0;
    if (s > 2047.0) s = 2047.0;
    if (s < -2048.0) s = -2048.0;
    tol = 24;
    return int'(s) * (1 << (DW - OW)) + MID;
  endfunction

  task automatic model_reset();
    rec_t r;
    m_acc = 0; m_inc = 0; m_ofs = 0; m_amp = 0; m_m1 = 3; m_m2 = 3;
    p_inc = 0; p_ofs = 0; p_amp = 0; p_m1 = 3; p_m2 = 3; p_clr = 0;
    m_busy = 0; m_imm = 0; m_ovr = 0;
    hist.delete();
    r.valid = 0; r.phase = 0; r.m1 = 3; r.m2 = 3; r.amp = 0;
    repeat (LAT) hist.push_back(r);
  endtask

  // One clock: predict from the pre-edge inputs, then compare every output after the edge.
  task automatic tick();
    rec_t r, o;
    int   sum, new_acc, tol1, tol2, e1, e2;
    bit   carry, apply, n_busy;
    r.valid = en; r.phase = (m_acc + m_ofs) % M; r.m1 = m_m1; r.m2 = m_m2; r.amp = m_amp;
    hist.push_back(r);
    sum    = m_acc + m_inc;
    carry  = en && (sum >= M);
    apply  = m_imm || (m_busy && carry);
    m_ovr  = cfg_commit && m_busy;
    n_busy = m_busy;
    new_acc = (apply && p_clr) ? 0 : (en ? sum % M : m_acc);
    if (apply) begin
      m_inc = p_inc; m_ofs = p_ofs; m_amp = p_amp; m_m1 = p_m1; m_m2 = p_m2;
    end
    m_imm = 0;
    if (cfg_commit && !m_busy) begin
      p_inc = int'(cfg_phase_inc); p_ofs = int'(cfg_phase_ofs); p_amp = int'(cfg_amp);
      p_m1 = int'(cfg_mode1); p_m2 = int'(cfg_mode2); p_clr = cfg_phase_clr;
      if (cfg_sync_wrap) n_busy = 1;
      else m_imm = 1;
    end
    if (m_busy && carry) n_busy = 0;
    m_busy = n_busy;
    m_acc  = new_acc;
    @(posedge sys_clk);
    #1;
    o  = hist.pop_front();
    e1 = exp_dac(o.valid, o.phase, o.m1, o.amp, tol1);
    e2 = exp_dac(o.valid, o.phase, o.m2, o.amp, tol2);
    checkOutput("busy", int'(cfg_busy), int'(m_busy), 0);
    checkOutput("ovr", int'(cfg_ovr), int'(m_ovr), 0);
    checkOutput("valid", int'(out_valid), int'(o.valid), 0);
    checkOutput("dac1", int'(dac1_data), e1, tol1);
    checkOutput("dac2", int'(dac2_data), e2, tol2);
  endtask

  task automatic applyStimulus(input bit e, input bit commit, input int inc, input int ofs,
                               input int amp, input int m1, input int m2, input bit sync,
                               input bit clr);
    en = e;
    cfg_commit = commit;
    cfg_phase_inc = PW'(inc); cfg_phase_ofs = PW'(ofs); cfg_amp = AW'(amp);
    cfg_mode1 = 2'(m1); cfg_mode2 = 2'(m2);
    cfg_sync_wrap = sync; cfg_phase_clr = clr;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic idle(input bit e, input int n);
    en = e;
    cfg_commit = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; en = 1'b0; cfg_commit = 1'b0;
    cfg_phase_inc = '0; cfg_phase_ofs = '0; cfg_amp = '0;
    cfg_mode1 = 2'b00; cfg_mode2 = 2'b00; cfg_sync_wrap = 1'b0; cfg_phase_clr = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("rst_dac1", int'(dac1_data), MID, 0);
    checkOutput("rst_dac2", int'(dac2_data), MID, 0);
    checkOutput("rst_valid", int'(out_valid), 0, 0);
    checkOutput("rst_busy", int'(cfg_busy), 0, 0);
    rst_n = 1'b1;
    model_reset();

    applyStimulus(1, 1, 0, 0, 2048, 0, 1, 0, 0);
    idle(1, 30);
    checkOutput("tp_sin0", int'(dac1_data), 8192, 8);
    checkOutput("tp_cos0", int'(dac2_data), 16380, 8);

    applyStimulus(1, 1, 0, 0, 1024, 0, 1, 0, 0);
    idle(1, 30);
    checkOutput("tp_half_cos", int'(dac2_data), 12286, 8);
    checkOutput("tp_half_sin", int'(dac1_data), 8192, 8);

    applyStimulus(1, 1, 0, 1 << 17, 2048, 3, 2, 0, 0);
    idle(1, 30);
    checkOutput("tp_mute", int'(dac1_data), 8192, 0);
    checkOutput("tp_neg_sin", int'(dac2_data), 8, 8);

    applyStimulus(1, 1, 0, 0, 4095, 0, 1, 0, 0);
    idle(1, 25);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("tp_sat", int'(dac2_data), 16380, 0);
    end

    applyStimulus(1, 1, 1 << 16, 0, 2048, 0, 1, 0, 1);
    idle(1, 1);
    applyStimulus(1, 1, 1 << 15, 0, 2048, 0, 1, 1, 0);
    checkOutput("tp_busy_set", int'(cfg_busy), 1, 0);
    idle(1, 1);
    applyStimulus(1, 1, 12345, 777, 100, 2, 2, 1, 0);
    checkOutput("tp_ovr_pulse", int'(cfg_ovr), 1, 0);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (!cfg_busy) break;
    end
    checkOutput("tp_wrap_cycles", n, 5, 0);
    idle(1, 30);

    applyStimulus(1, 1, 3000, 0, 2048, 0, 1, 1, 0);
    idle(1, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_dac1", int'(dac1_data), MID, 0);
    checkOutput("rst_mid_dac2", int'(dac2_data), MID, 0);
    checkOutput("rst_mid_valid", int'(out_valid), 0, 0);
    checkOutput("rst_mid_busy", int'(cfg_busy), 0, 0);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    applyStimulus(1, 1, 1 << 14, 0, 2048, 0, 1, 0, 0);
    idle(1, 40);

    for (int i = 0; i < 400; i++) begin
      bit e, c;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 5) == 0);
      applyStimulus(e, c, $urandom_range(0, M - 1), $urandom_range(0, M - 1),
                    $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    end
    idle(1, LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
